mips_multicycle_core: RTL

Multicycle 32-bit MIPS core: the successor to the single-cycle core, with one shared instruction/data memory port and a ready handshake that tolerates any number of wait states. Decoder, FSM controller, register file and ALU are all inside this block; it sits between the top level and a single unified memory. A mode parameter adds `bne`/`ori`, and an illegal opcode halts the core with a sticky flag.

---
 rtl/mips_multicycle_core.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// Multicycle 32-bit MIPS core with a single shared instruction/data memory port.
// A ready handshake stalls any memory state for as many cycles as needed.
// Optional ISA extension (EXT_ISA) adds bne and ori; an illegal op parks the
// core in HALT until reset.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          EXT_ISA  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] ir_reg, a_reg, b_reg, alu_out_reg, mdr_reg, target_reg;
    logic [31:0] rf_reg [0:31];

    // Control strobes produced by the FSM
    logic        ir_load, ab_load, alu_load, mdr_load, pc_load, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    // Instruction fields and derived values
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, alu_dest;
    logic [31:0] sext_imm, zext_imm, pc_plus4, jump_target, alu_result;
    logic        funct_legal, branch_taken;

    assign op          = ir_reg[31:26];
    assign rs          = ir_reg[25:21];
    assign rt          = ir_reg[20:16];
    assign rd          = ir_reg[15:11];
    assign funct       = ir_reg[5:0];
    assign sext_imm    = {{16{ir_reg[15]}}, ir_reg[15:0]};
    assign zext_imm    = {16'h0000, ir_reg[15:0]};
    assign pc_plus4    = pc_reg + 32'd4;
    assign jump_target = {pc_plus4[31:28], ir_reg[25:0], 2'b00};
    assign alu_dest    = (op == OP_RTYPE) ? rd : rt;
    assign pc          = pc_reg;

    // Legal R-type function codes
    always_comb begin
        funct_legal = 1'b0;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_legal = 1'b1;
            default:                               funct_legal = 1'b0;
        endcase
    end

    // ALU: default path is A + sext(imm), shared by addi and load/store addressing
    always_comb begin
        alu_result = a_reg + sext_imm;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_SUB:  alu_result = a_reg - b_reg;
                FN_AND:  alu_result = a_reg & b_reg;
                FN_OR:   alu_result = a_reg | b_reg;
                FN_SLT:  alu_result = {31'b0, ($signed(a_reg) < $signed(b_reg))};
                default: alu_result = a_reg + b_reg;
            endcase
        end else if (op == OP_ORI) begin
            alu_result = a_reg | zext_imm;
        end
    end

    assign branch_taken = (op == OP_BNE) ? (a_reg != b_reg) : (a_reg == b_reg);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_START;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic, memory port drive and datapath strobes.
    // Port outputs come from registered state/datapath; the only use of
    // mem_ready on an output is the store retire, which lands in the ready cycle.
    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        retire     = 1'b0;
        halted     = 1'b0;
        ir_load    = 1'b0;
        ab_load    = 1'b0;
        alu_load   = 1'b0;
        mdr_load   = 1'b0;
        pc_load    = 1'b0;
        pc_next    = pc_plus4;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        case (state_reg)
            S_START: state_next = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_reg;
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ab_load = 1'b1;
                case (op)
                    OP_RTYPE: state_next = funct_legal ? S_EXEC : S_HALT;
                    OP_ADDI:  state_next = S_EXEC;
                    OP_ORI:   state_next = EXT_ISA ? S_EXEC : S_HALT;
                    OP_LW,
                    OP_SW:    state_next = S_MEMADR;
                    OP_BEQ:   state_next = S_BRANCH;
                    OP_BNE:   state_next = EXT_ISA ? S_BRANCH : S_HALT;
                    OP_J:     state_next = S_JUMP;
                    default:  state_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_load   = 1'b1;
                state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req  = 1'b1;
                mem_addr = alu_out_reg;
                if (mem_ready) begin
                    mdr_load   = 1'b1;
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                rf_we      = (rt != 5'd0);
                rf_waddr   = rt;
                rf_wdata   = mdr_reg;
                retire     = 1'b1;
                pc_load    = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = alu_out_reg;
                mem_wdata = b_reg;
                if (mem_ready) begin
                    retire     = 1'b1;
                    pc_load    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_load   = 1'b1;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we      = (alu_dest != 5'd0);
                rf_waddr   = alu_dest;
                rf_wdata   = alu_out_reg;
                retire     = 1'b1;
                pc_load    = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                retire     = 1'b1;
                pc_load    = 1'b1;
                pc_next    = branch_taken ? target_reg : pc_plus4;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                retire     = 1'b1;
                pc_load    = 1'b1;
                pc_next    = jump_target;
                state_next = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: state_next = S_START;
        endcase
    end

    // Datapath registers: IR, A/B, branch target, ALUOut, MDR and PC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg      <= RESET_PC;
            ir_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            target_reg  <= '0;
            alu_out_reg <= '0;
            mdr_reg     <= '0;
        end else begin
            if (ir_load) ir_reg <= mem_rdata;
            if (ab_load) begin
                a_reg      <= rf_reg[rs];
                b_reg      <= rf_reg[rt];
                target_reg <= pc_plus4 + {sext_imm[29:0], 2'b00};
            end
            if (alu_load) alu_out_reg <= alu_result;
            if (mdr_load) mdr_reg <= mem_rdata;
            if (pc_load)  pc_reg <= pc_next;
        end
    end

    // Register file: entry 0 is never written, so it holds its reset value of 0
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rf
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rf_reg[gi] <= '0;
                end else if (rf_we && (rf_waddr == 5'(gi))) begin
                    rf_reg[gi] <= rf_wdata;
                end
            end
        end
    endgenerate
endmodule
